// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// EX-stage execution unit driven by the 4-bit ALUOp code from the ALU control
// decoder. Logic, arithmetic, shift and compare operations complete in one
// edge. Multiplies (mul/mult/multu/madd/msub) run an iterative shift-add over
// WIDTH edges followed by one finishing edge, updating the HI/LO pair. The
// pipeline keeps operands stable and stalls while Busy is high.
//
// Ports
//   Clk         rising-edge clock
//   Rst_n       asynchronous active-low reset
//   Start       execute ALUOp on A/B; sampled only when Busy=0
//   ALUOp[3:0]  operation code (1111 = multiply family, selected by MulSel)
//   MulSel[2:0] 000 mul, 001 mult, 010 multu, 011 madd, 100 msub
//   ShiftArith  with ALUOp=0101: 1 = SRA, 0 = SRL
//   ShAmt[4:0]  shift amount
//   A, B        operands (B is the shifted operand for shifts)
//   WrHi, WrLo  mthi/mtlo: load Hi/Lo from A when idle and Start=0
//   Result      registered result
//   Zero        registered, 1 when Result == 0
//   Hi, Lo      HI/LO registers
//   Busy        multiply in progress
//   Done        one-cycle pulse, Result (and Hi/Lo) valid
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [3:0]       ALUOp,
    input  logic [2:0]       MulSel,
    input  logic             ShiftArith,
    input  logic [4:0]       ShAmt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WrHi,
    input  logic             WrLo,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRX  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_MULT = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        MS_MUL   = 3'b000,
        MS_MULT  = 3'b001,
        MS_MULTU = 3'b010,
        MS_MADD  = 3'b011,
        MS_MSUB  = 3'b100
    } mul_sel_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FINISH
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e               state_q;
    logic [WIDTH-1:0]     result_q;
    logic                 zero_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   prod_q;     // {partial sum, remaining multiplier bits}
    logic [WIDTH-1:0]     mcand_q;    // multiplicand magnitude
    logic [CNT_W-1:0]     cnt_q;      // iterations completed
    logic                 neg_q;      // product sign for signed variants
    mul_sel_e             msel_q;

    // -------------------------------------------------------------------------
    // Next-state / datapath signals
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]     alu_res_d;
    logic                 mul_accept_d;
    logic                 signed_mul_d;
    logic [WIDTH-1:0]     mag_a_d;
    logic [WIDTH-1:0]     mag_b_d;
    logic [WIDTH:0]       add_d;
    logic [2*WIDTH-1:0]   prod_step_d;
    logic [2*WIDTH-1:0]   prod_signed_d;
    logic [2*WIDTH-1:0]   hilo_d;

    // Single-cycle ALU result; reserved codes (including a multiply with a
    // reserved MulSel) fall to the default and produce zero.
    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_res_d = '0;
        unique case (ALUOp)
            OP_AND:  alu_res_d = A & B;
            OP_OR:   alu_res_d = A | B;
            OP_ADD:  alu_res_d = A + B;
            OP_XOR:  alu_res_d = A ^ B;
            OP_SLL:  alu_res_d = B << ShAmt;
            OP_SRX:  alu_res_d = ShiftArith ? WIDTH'($signed(B) >>> ShAmt)
                                            : (B >> ShAmt);
            OP_SUB:  alu_res_d = A - B;
            OP_NOR:  alu_res_d = ~(A | B);
            OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, (A < B)};
            default: alu_res_d = '0;
        endcase
    end

    // Multiply acceptance and operand conditioning. Signed variants run the
    // unsigned shift-add on magnitudes and negate at the end; the magnitude of
    // the most negative value is itself, which is correct as an unsigned number.
    always_comb begin
        mul_accept_d = Start && (ALUOp == OP_MULT) && (MulSel <= MS_MSUB);
        signed_mul_d = (MulSel == MS_MULT) || (MulSel == MS_MADD) ||
                       (MulSel == MS_MSUB);
        mag_a_d      = (signed_mul_d && A[WIDTH-1]) ? (~A + 1'b1) : A;
        mag_b_d      = (signed_mul_d && B[WIDTH-1]) ? (~B + 1'b1) : B;
    end

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole register right,
    // keeping the carry as the new top bit.
    always_comb begin
        add_d         = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                        (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step_d   = {add_d, prod_q[WIDTH-1:1]};
        prod_signed_d = neg_q ? (~prod_q + 1'b1) : prod_q;
    end

    // HI/LO update applied on the finishing edge; madd/msub wrap naturally.
    always_comb begin
        hilo_d = {hi_q, lo_q};
        unique case (msel_q)
            MS_MULT, MS_MULTU: hilo_d = prod_signed_d;
            MS_MADD:           hilo_d = {hi_q, lo_q} + prod_signed_d;
            MS_MSUB:           hilo_d = {hi_q, lo_q} - prod_signed_d;
            default:           hilo_d = {hi_q, lo_q};
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            msel_q   <= MS_MUL;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        if (mul_accept_d) begin
                            prod_q  <= {{WIDTH{1'b0}}, mag_a_d};
                            mcand_q <= mag_b_d;
                            neg_q   <= signed_mul_d && (A[WIDTH-1] ^ B[WIDTH-1]);
                            msel_q  <= mul_sel_e'(MulSel);
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_MUL;
                        end else begin
                            result_q <= alu_res_d;
                            zero_q   <= (alu_res_d == '0);
                            done_q   <= 1'b1;
                        end
                    end else begin
                        // mthi/mtlo only when no operation is being issued.
                        if (WrHi) hi_q <= A;
                        if (WrLo) lo_q <= A;
                    end
                end

                S_MUL: begin
                    prod_q <= prod_step_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    result_q <= prod_signed_d[WIDTH-1:0];
                    zero_q   <= (prod_signed_d[WIDTH-1:0] == '0);
                    if (msel_q != MS_MUL) begin
                        {hi_q, lo_q} <= hilo_d;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Result = result_q;
    assign Zero   = zero_q;
    assign Hi     = hi_q;
    assign Lo     = lo_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Self-checking bench for alu_exec_unit. Directed cases cover the documented
// corner cases; random single-cycle ops and multiplies are compared against
// an arithmetic reference model of the operations and of the HI/LO pair.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         Start;
    logic [3:0]   ALUOp;
    logic [2:0]   MulSel;
    logic         ShiftArith;
    logic [4:0]   ShAmt;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         WrHi;
    logic         WrLo;
    logic [W-1:0] Result;
    logic         Zero;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic         Busy;
    logic         Done;

    alu_exec_unit #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Start      (Start),
        .ALUOp      (ALUOp),
        .MulSel     (MulSel),
        .ShiftArith (ShiftArith),
        .ShAmt      (ShAmt),
        .A          (A),
        .B          (B),
        .WrHi       (WrHi),
        .WrLo       (WrLo),
        .Result     (Result),
        .Zero       (Zero),
        .Hi         (Hi),
        .Lo         (Lo),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference HI/LO pair.
    logic [63:0] m_hilo;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference for single-cycle operations.
    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [4:0] sh,
                                            input logic sa);
        logic [31:0] r;
        longint sa_a, sa_b;
        sa_a = $signed(a);
        sa_b = $signed(b);
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd3:    r = a ^ b;
            4'd4:    r = b << sh;
            4'd5: begin
                r = b >> sh;
                if (sa && b[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'd6:    r = a - b;
            4'd7:    r = ~(a | b);
            4'd8:    r = (sa_a < sa_b) ? 32'd1 : 32'd0;
            4'd9:    r = (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic clear_inputs();
        Start = 1'b0; ALUOp = 4'd0; MulSel = 3'd0; ShiftArith = 1'b0;
        ShAmt = 5'd0; A = '0; B = '0; WrHi = 1'b0; WrLo = 1'b0;
    endtask

    // Issue one single-cycle op and check its result one edge later.
    task automatic run_single(input string tag, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input logic sa,
                              input logic [2:0] msel, input logic wrh,
                              input logic wrl);
        logic [31:0] exp;
        exp = ref_alu(op, a, b, sh, sa);
        @(negedge Clk);
        ALUOp = op; A = a; B = b; ShAmt = sh; ShiftArith = sa; MulSel = msel;
        WrHi = wrh; WrLo = wrl; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
        check({tag, "/res"},  64'(Result), 64'(exp));
        check({tag, "/zero"}, 64'(Zero),   64'(exp == 32'd0));
        check({tag, "/done"}, 64'(Done),   64'd1);
        check({tag, "/hilo"}, {Hi, Lo},    m_hilo);
        @(posedge Clk); #1;
        check({tag, "/done_off"}, 64'(Done), 64'd0);
    endtask

    // Issue a multiply; optionally poke Start+ADD+WrHi while busy.
    task automatic run_mul(input string tag, input logic [2:0] msel,
                           input logic [31:0] a, input logic [31:0] b,
                           input bit inject);
        logic [63:0] p;
        longint      sa_a, sa_b;
        int          busy_cyc;
        int          edges;
        bit          done_seen;
        if (msel == 3'd1 || msel == 3'd3 || msel == 3'd4) begin
            sa_a = $signed(a);
            sa_b = $signed(b);
            p = 64'(sa_a * sa_b);
        end else begin
            p = 64'(a) * 64'(b);
        end
        @(negedge Clk);
        ALUOp = 4'hF; MulSel = msel; A = a; B = b; WrHi = 1'b0; WrLo = 1'b0;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        // Operands may change after acceptance without effect.
        A = $urandom(); B = $urandom(); ALUOp = 4'($urandom_range(0, 15));
        MulSel = 3'($urandom_range(0, 7));
        check({tag, "/busy_start"}, 64'(Busy), 64'd1);
        busy_cyc  = 1;
        edges     = 0;
        done_seen = 0;
        for (int i = 1; i <= 40 && !done_seen; i++) begin
            if (inject && i == 5) begin
                ALUOp = 4'd2; Start = 1'b1; WrHi = 1'b1; A = $urandom();
            end
            @(posedge Clk); #1;
            Start = 1'b0; WrHi = 1'b0;
            if (Done) begin
                done_seen = 1;
                edges     = i;
            end else if (Busy) begin
                busy_cyc++;
            end
        end
        case (msel)
            3'd1, 3'd2: m_hilo = p;
            3'd3:       m_hilo = m_hilo + p;
            3'd4:       m_hilo = m_hilo - p;
            default:    m_hilo = m_hilo;
        endcase
        check({tag, "/done_seen"}, 64'(done_seen), 64'd1);
        check({tag, "/latency"},   64'(edges),     64'd33);
        check({tag, "/busy_cyc"},  64'(busy_cyc),  64'd33);
        check({tag, "/busy_end"},  64'(Busy),      64'd0);
        check({tag, "/res"},       64'(Result),    64'(p[31:0]));
        check({tag, "/zero"},      64'(Zero),      64'(p[31:0] == 32'd0));
        check({tag, "/hilo"},      {Hi, Lo},       m_hilo);
        @(posedge Clk); #1;
        check({tag, "/done_off"},  64'(Done),      64'd0);
    endtask

    task automatic write_hilo(input string tag, input logic wrh,
                              input logic wrl, input logic [31:0] a);
        @(negedge Clk);
        WrHi = wrh; WrLo = wrl; A = a; Start = 1'b0;
        @(posedge Clk); #1;
        WrHi = 1'b0; WrLo = 1'b0;
        if (wrh) m_hilo[63:32] = a;
        if (wrl) m_hilo[31:0]  = a;
        check({tag, "/hilo"}, {Hi, Lo}, m_hilo);
        check({tag, "/done"}, 64'(Done), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/res"},  64'(Result), 64'd0);
        check({tag, "/zero"}, 64'(Zero),   64'd0);
        check({tag, "/hi"},   64'(Hi),     64'd0);
        check({tag, "/lo"},   64'(Lo),     64'd0);
        check({tag, "/busy"}, 64'(Busy),   64'd0);
        check({tag, "/done"}, 64'(Done),   64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]  op;
        logic [2:0]  ms;
        logic [31:0] ra, rb;

        clear_inputs();
        m_hilo = '0;
        Rst_n  = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge Clk);
        Rst_n = 1'b1;

        // Directed single-cycle cases.
        run_single("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        run_single("sub_zero", 4'd6, 32'd5, 32'd5, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        run_single("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        run_single("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        run_single("sra", 4'd5, 32'd0, 32'h8000_0000, 5'd4, 1'b1, 3'd0, 1'b0, 1'b0);
        run_single("srl", 4'd5, 32'd0, 32'h8000_0000, 5'd4, 1'b0, 3'd0, 1'b0, 1'b0);
        run_single("sll0", 4'd4, 32'd0, 32'hDEAD_BEEF, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        run_single("rsv_op", 4'd12, 32'h1234, 32'h5678, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        run_single("rsv_msel", 4'hF, 32'd7, 32'd9, 5'd0, 1'b0, 3'd6, 1'b0, 1'b0);
        // Start has priority over mthi/mtlo in the same cycle.
        run_single("start_prio", 4'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Directed multiplies.
        run_mul("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_mul("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        write_hilo("mtlo", 1'b0, 1'b1, 32'd10);
        write_hilo("mthi", 1'b1, 1'b0, 32'd0);
        run_mul("madd", 3'd3, 32'd3, 32'd4, 1'b0);
        run_mul("msub", 3'd4, 32'd1, 32'd23, 1'b0);
        run_mul("mult_inject", 3'd1, 32'h0001_2345, 32'hFFFF_F000, 1'b1);
        run_mul("mul_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_mul("mult_min", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Random single-cycle ops, including reserved codes.
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            ms = (op == 4'hF) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 7));
            ra = $urandom();
            rb = (i % 5 == 0) ? 32'h8000_0000 | $urandom() : $urandom();
            run_single("rnd_op", op, ra, rb, 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), ms,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Random multiplies interleaved with HI/LO writes.
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0)
                write_hilo("rnd_wr", 1'b1, 1'b1, $urandom());
            run_mul("rnd_mul", 3'($urandom_range(0, 4)), $urandom(), $urandom(),
                    1'(i % 3 == 0));
        end

        // Reset in the middle of a multiply.
        @(negedge Clk);
        ALUOp = 4'hF; MulSel = 3'd1; A = 32'h0000_1234; B = 32'h0000_5678;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        for (int i = 0; i < 10; i++) @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        m_hilo = '0;
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            check("post_reset/done", 64'(Done), 64'd0);
            check("post_reset/busy", 64'(Busy), 64'd0);
        end
        run_single("post_reset_add", 4'd2, 32'd100, 32'd23, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (Done) check("stray_done", 64'(Done), 64'd0);
        end
        check("idle_done", 64'(Done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
